// File: rtl/fetch_issue_buffer.sv
// Fetch-to-issue instruction buffer: a small circular FIFO between the fetch
// and issue stages with registered full/empty status.
// Optional macro FETCH_ISSUE_BYPASS_EN adds a zero-latency bypass from fetch
// straight to issue when the buffer is empty and issue can accept.
module fetch_issue_buffer #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               fi_instrv_i,
    input  logic [INSTR_W-1:0] fi_instr_i,
    output logic               fi_busy_o,
    output logic               is_instrv_o,
    output logic [INSTR_W-1:0] is_instr_o,
    input  logic               is_busy_i,
    output logic [AW:0]        count_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;

    logic full;
    logic empty;
    logic bypass;
    logic push_wr;
    logic pop_rd;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

`ifdef FETCH_ISSUE_BYPASS_EN
    // Empty buffer and a willing issue stage: hand the fetch word straight through.
    assign bypass      = empty & fi_instrv_i & ~is_busy_i & ~flush_i;
    assign is_instrv_o = ~empty | bypass;
    assign is_instr_o  = bypass ? fi_instr_i : mem_q[rd_ptr_q];
`else
    assign bypass      = 1'b0;
    assign is_instrv_o = ~empty;
    assign is_instr_o  = mem_q[rd_ptr_q];
`endif

    // Busy is taken from registered count only, so a same-cycle pop never frees a slot early.
    assign fi_busy_o = full;
    assign count_o   = count_q;

    // A bypassed instruction is consumed without touching storage.
    assign push_wr = fi_instrv_i & ~full & ~flush_i & ~bypass;
    assign pop_rd  = ~empty & ~is_busy_i;

    // Next-state for pointers and occupancy; flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_wr) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_rd) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + {{AW{1'b0}}, push_wr} - {{AW{1'b0}}, pop_rd};
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset; contents are qualified by count.
    always_ff @(posedge clk) begin
        if (push_wr) begin
            mem_q[wr_ptr_q] <= fi_instr_i;
        end
    end

endmodule

// File: tb/tb_fetch_issue_buffer.sv
// Scoreboard bench for fetch_issue_buffer (DEPTH=4, INSTR_W=32).
// Directed stimulus pushes hand-chosen expected words into a queue; a monitor
// pops and compares every word the DUT hands to issue.
module tb_fetch_issue_buffer;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_i;
    logic          fi_instrv_i;
    logic [W-1:0]  fi_instr_i;
    logic          fi_busy_o;
    logic          is_instrv_o;
    logic [W-1:0]  is_instr_o;
    logic          is_busy_i;
    logic [2:0]    count_o;

    int n_total = 0;
    int n_pass  = 0;
    logic [W-1:0] exp_q [$];

    fetch_issue_buffer #(
        .INSTR_W (W),
        .DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .fi_instrv_i (fi_instrv_i),
        .fi_instr_i  (fi_instr_i),
        .fi_busy_o   (fi_busy_o),
        .is_instrv_o (is_instrv_o),
        .is_instr_o  (is_instr_o),
        .is_busy_i   (is_busy_i),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endfunction

    // Monitor: a word handed over at mid-cycle is popped at the next edge.
    always @(negedge clk) begin
        if (rst_n && is_instrv_o && !is_busy_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_issue: got 0x%0h, want nothing", is_instr_o);
            end else begin
                chk("issue_order", is_instr_o, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until the buffer takes it.
    task automatic push_one(input logic [W-1:0] v);
        logic acc;
        acc = 1'b0;
        fi_instrv_i = 1'b1;
        fi_instr_i  = v;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = !fi_busy_o;
            tick();
        end
        fi_instrv_i = 1'b0;
        if (!acc) chk("push_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        is_busy_i = 1'b0;
        for (int i = 0; i < 20 && count_o != 0; i++) tick();
        chk("drain_count", W'(count_o), 0);
        chk("sb_empty", W'(exp_q.size()), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        fi_instrv_i = 1'b0;
        fi_instr_i  = '0;
        is_busy_i   = 1'b0;
        #12;
        chk("rst_count", W'(count_o), 0);
        chk("rst_instrv", W'(is_instrv_o), 0);
        chk("rst_fi_busy", W'(fi_busy_o), 0);
        rst_n = 1'b1;
        tick();

        // Single push into empty buffer.
        fi_instrv_i = 1'b1;
        fi_instr_i  = 32'h11;
        exp_q.push_back(32'h11);
`ifdef FETCH_ISSUE_BYPASS_EN
        #1;
        chk("byp_instrv", W'(is_instrv_o), 1);
        chk("byp_instr", is_instr_o, 32'h11);
`else
        #1;
        chk("no_comb_path", W'(is_instrv_o), 0);
`endif
        tick();
        fi_instrv_i = 1'b0;
`ifndef FETCH_ISSUE_BYPASS_EN
        chk("lat1_instrv", W'(is_instrv_o), 1);
        chk("lat1_instr", is_instr_o, 32'h11);
        chk("lat1_count", W'(count_o), 1);
        tick();
`endif
        chk("single_count0", W'(count_o), 0);
        chk("single_instrv0", W'(is_instrv_o), 0);

        // Fill to full with issue stalled, fifth word held.
        is_busy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'hA0 + W'(i));
            push_one(32'hA0 + W'(i));
        end
        chk("full_count", W'(count_o), 4);
        chk("full_busy", W'(fi_busy_o), 1);
        chk("full_instr_stable", is_instr_o, 32'hA0);
        fi_instrv_i = 1'b1;
        fi_instr_i  = 32'hA4;
        exp_q.push_back(32'hA4);
        tick();
        tick();
        chk("held_count", W'(count_o), 4);
        chk("held_busy", W'(fi_busy_o), 1);
        is_busy_i = 1'b0;
        tick();
        chk("full_pop_no_push", W'(count_o), 3);
        chk("busy_released", W'(fi_busy_o), 0);
        tick();
        fi_instrv_i = 1'b0;
        chk("push_pop_after_full", W'(count_o), 3);
        drain();

        // Steady push+pop at count 2 with pointer wrap.
        is_busy_i = 1'b1;
        exp_q.push_back(32'hB0);
        push_one(32'hB0);
        exp_q.push_back(32'hB1);
        push_one(32'hB1);
        is_busy_i   = 1'b0;
        fi_instrv_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fi_instr_i = 32'hB2 + W'(i);
            exp_q.push_back(32'hB2 + W'(i));
            tick();
            chk("stream_count", W'(count_o), 2);
        end
        fi_instrv_i = 1'b0;
        drain();

        // Flush wins over a concurrent push.
        is_busy_i = 1'b1;
        push_one(32'hC0);
        push_one(32'hC1);
        push_one(32'hC2);
        chk("pre_flush_count", W'(count_o), 3);
        flush_i     = 1'b1;
        fi_instrv_i = 1'b1;
        fi_instr_i  = 32'h55;
        tick();
        flush_i     = 1'b0;
        fi_instrv_i = 1'b0;
        chk("flush_count", W'(count_o), 0);
        chk("flush_instrv", W'(is_instrv_o), 0);
        is_busy_i = 1'b0;
        exp_q.push_back(32'h66);
        push_one(32'h66);
        drain();

        // Asynchronous reset mid-cycle.
        is_busy_i = 1'b1;
        push_one(32'hD0);
        push_one(32'hD1);
        push_one(32'hD2);
        chk("pre_rst_count", W'(count_o), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", W'(count_o), 0);
        chk("arst_instrv", W'(is_instrv_o), 0);
        chk("arst_fi_busy", W'(fi_busy_o), 0);
        rst_n = 1'b1;
        is_busy_i = 1'b0;
        tick();
        exp_q.push_back(32'hE0);
        push_one(32'hE0);
        drain();

`ifdef FETCH_ISSUE_BYPASS_EN
        // Bypass, then the same word with issue stalled goes into storage.
        fi_instrv_i = 1'b1;
        fi_instr_i  = 32'h77;
        exp_q.push_back(32'h77);
        #1;
        chk("byp77_instr", is_instr_o, 32'h77);
        tick();
        fi_instrv_i = 1'b0;
        chk("byp77_count", W'(count_o), 0);
        is_busy_i = 1'b1;
        exp_q.push_back(32'h77);
        push_one(32'h77);
        chk("byp77_busy_count", W'(count_o), 1);
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
